// File: rtl/wb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : wb_initiator
// Purpose  : Single-outstanding Wishbone classic master. Accepts one command
//            on a valid/ready channel, runs one bus cycle (ends on ack, or is
//            abandoned after TIMEOUT cycles without ack), and returns the
//            result on a valid/ready response channel.
// Ports    :
//   wb_clk_i, wb_rst_ni                  clock, async active-low reset
//   cmd_valid_i/cmd_ready_o              command handshake
//   cmd_we_i, cmd_adr_i, cmd_dat_i,
//   cmd_sel_i                            command payload
//   rsp_valid_o/rsp_ready_i              response handshake
//   rsp_dat_o, rsp_timeout_o             response payload
//   wbm_cyc_o, wbm_stb_o, wbm_we_o,
//   wbm_adr_o, wbm_dat_o, wbm_sel_o      Wishbone master outputs
//   wbm_ack_i, wbm_dat_i                 Wishbone slave ack / read data
// Revision : 1.0 - initial release
// ============================================================================
module wb_initiator #(
    parameter int unsigned TIMEOUT = 255   // legal range 1..65535
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_timeout_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Last wait-counter value of a bus cycle; the cycle spans TIMEOUT clocks.
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;
    logic        ready_en;     // low during reset and until the first edge after release
    logic        cmd_accept;
    logic        timeout_hit;

    // ------------------------------------------------------------------------
    // Handshake and completion qualifiers
    // ------------------------------------------------------------------------
    assign cmd_ready_o = (state == ST_IDLE) && ready_en;
    assign cmd_accept  = cmd_valid_i && cmd_ready_o;
    assign rsp_valid_o = (state == ST_RESP);
    // Ack has priority: a timeout only fires on a cycle without ack.
    assign timeout_hit = (state == ST_BUS) && !wbm_ack_i && (wait_cnt == TIMEOUT_LAST);

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (cmd_accept)               state_nxt = ST_BUS;
            ST_BUS:  if (wbm_ack_i || timeout_hit) state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready_i)              state_nxt = ST_IDLE;
            default:                               state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Reset-release qualifier: cmd_ready rises on the first edge after release
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Bus-side and response datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbm_cyc_o     <= 1'b0;
            wbm_stb_o     <= 1'b0;
            wbm_we_o      <= 1'b0;
            wbm_adr_o     <= 32'h0;
            wbm_dat_o     <= 32'h0;
            wbm_sel_o     <= 4'h0;
            rsp_dat_o     <= 32'h0;
            rsp_timeout_o <= 1'b0;
            wait_cnt      <= 16'h0;
        end else if (cmd_accept) begin
            // Command is latched straight into the bus outputs; the bus
            // cycle starts on the next clock and holds these until it ends.
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            wbm_we_o  <= cmd_we_i;
            wbm_adr_o <= cmd_adr_i;
            wbm_dat_o <= cmd_dat_i;
            wbm_sel_o <= cmd_sel_i;
            wait_cnt  <= 16'h0;
        end else if (state == ST_BUS) begin
            if (wbm_ack_i) begin
                wbm_cyc_o     <= 1'b0;
                wbm_stb_o     <= 1'b0;
                rsp_dat_o     <= wbm_we_o ? 32'h0 : wbm_dat_i;
                rsp_timeout_o <= 1'b0;
            end else if (timeout_hit) begin
                wbm_cyc_o     <= 1'b0;
                wbm_stb_o     <= 1'b0;
                rsp_dat_o     <= 32'hFFFF_FFFF;
                rsp_timeout_o <= 1'b1;
            end else begin
                wait_cnt <= wait_cnt + 16'd1;
            end
        end
        // In IDLE and RESP nothing changes: response fields stay stable
        // under backpressure and stray acks are ignored.
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_initiator.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_initiator
// Purpose  : Directed self-checking bench for wb_initiator (TIMEOUT = 8).
//            Inputs change 1 ns after a rising edge; outputs are checked at
//            the same point, i.e. showing the effect of the preceding edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_initiator;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_timeout;
    logic        wbm_cyc;
    logic        wbm_stb;
    logic        wbm_we;
    logic [31:0] wbm_adr;
    logic [31:0] wbm_dat;
    logic [3:0]  wbm_sel;
    logic        wbm_ack;
    logic [31:0] wbm_dat_in;

    int passed = 0;
    int total  = 0;

    wb_initiator #(.TIMEOUT(8)) dut (
        .wb_clk_i      (clk),
        .wb_rst_ni     (rst_n),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_we_i      (cmd_we),
        .cmd_adr_i     (cmd_adr),
        .cmd_dat_i     (cmd_dat),
        .cmd_sel_i     (cmd_sel),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_dat_o     (rsp_dat),
        .rsp_timeout_o (rsp_timeout),
        .wbm_cyc_o     (wbm_cyc),
        .wbm_stb_o     (wbm_stb),
        .wbm_we_o      (wbm_we),
        .wbm_adr_o     (wbm_adr),
        .wbm_dat_o     (wbm_dat),
        .wbm_sel_o     (wbm_sel),
        .wbm_ack_i     (wbm_ack),
        .wbm_dat_i     (wbm_dat_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bus outputs and response channel idle
    task automatic chk_idle(input string tag);
        chk({tag, "_cyc"},   {31'h0, wbm_cyc},   32'h0);
        chk({tag, "_stb"},   {31'h0, wbm_stb},   32'h0);
        chk({tag, "_rspv"},  {31'h0, rsp_valid}, 32'h0);
    endtask

    task automatic chk_bus(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
        chk({tag, "_cyc"}, {31'h0, wbm_cyc},   32'h1);
        chk({tag, "_stb"}, {31'h0, wbm_stb},   32'h1);
        chk({tag, "_we"},  {31'h0, wbm_we},    {31'h0, we});
        chk({tag, "_adr"}, wbm_adr,            adr);
        chk({tag, "_dat"}, wbm_dat,            dat);
        chk({tag, "_sel"}, {28'h0, wbm_sel},   {28'h0, sel});
        chk({tag, "_rdy"}, {31'h0, cmd_ready}, 32'h0);
    endtask

    task automatic chk_rsp(input string tag, input logic [31:0] dat, input logic to);
        chk({tag, "_rspv"}, {31'h0, rsp_valid},   32'h1);
        chk({tag, "_rspd"}, rsp_dat,              dat);
        chk({tag, "_rspt"}, {31'h0, rsp_timeout}, {31'h0, to});
        chk({tag, "_cyc"},  {31'h0, wbm_cyc},     32'h0);
        chk({tag, "_rdy"},  {31'h0, cmd_ready},   32'h0);
    endtask

    task automatic set_cmd(input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
    endtask

    initial begin
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_we     = 1'b0;
        cmd_adr    = 32'h0;
        cmd_dat    = 32'h0;
        cmd_sel    = 4'h0;
        rsp_ready  = 1'b0;
        wbm_ack    = 1'b0;
        wbm_dat_in = 32'h0;

        // ---------------- Reset state ----------------
        #3;
        chk_idle("rst");
        chk("rst_rdy",  {31'h0, cmd_ready},   32'h0);
        chk("rst_adr",  wbm_adr,              32'h0);
        chk("rst_rspd", rsp_dat,              32'h0);
        chk("rst_rspt", {31'h0, rsp_timeout}, 32'h0);
        tick(2);
        chk("rst_hold_rdy", {31'h0, cmd_ready}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_rdy_before_edge", {31'h0, cmd_ready}, 32'h0);
        tick(1);
        chk("rel_rdy_after_edge", {31'h0, cmd_ready}, 32'h1);
        chk_idle("rel");

        // ---------------- Write, ack after 2 wait cycles ----------------
        set_cmd(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        tick(1);
        cmd_valid = 1'b0;
        chk_bus("wr_c1", 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        tick(1);
        chk_bus("wr_c2", 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        tick(1);
        chk_bus("wr_c3", 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        wbm_ack    = 1'b1;
        wbm_dat_in = 32'h5555_AAAA;   // must not leak into a write response
        tick(1);
        wbm_ack = 1'b0;
        chk_rsp("wr_rsp", 32'h0, 1'b0);
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        chk_idle("wr_done");
        chk("wr_done_rdy", {31'h0, cmd_ready}, 32'h1);

        // ---------------- Read, ack in first stb cycle ----------------
        set_cmd(1'b0, 32'h3000_0000, 32'h0, 4'hF);
        tick(1);
        cmd_valid = 1'b0;
        chk_bus("rd_c1", 1'b0, 32'h3000_0000, 32'h0, 4'hF);
        wbm_ack    = 1'b1;
        wbm_dat_in = 32'h1234_5678;
        tick(1);
        wbm_ack    = 1'b0;
        wbm_dat_in = 32'h0;
        chk_rsp("rd_rsp", 32'h1234_5678, 1'b0);

        // ---------------- Backpressure for 10 cycles ----------------
        set_cmd(1'b0, 32'h3000_0008, 32'h0, 4'h3);   // offered but must wait
        for (int i = 0; i < 10; i++) begin
            wbm_dat_in = 32'hC0DE_0000 + i;
            tick(1);
            chk_rsp($sformatf("bp%0d", i), 32'h1234_5678, 1'b0);
        end
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        chk_idle("bp_hs");
        chk("bp_hs_rdy", {31'h0, cmd_ready}, 32'h1);
        tick(1);
        cmd_valid = 1'b0;
        // ---------------- Timeout, no ack (TIMEOUT = 8) ----------------
        chk_bus("to_c1", 1'b0, 32'h3000_0008, 32'h0, 4'h3);
        for (int c = 2; c <= 8; c++) begin
            tick(1);
            chk($sformatf("to_c%0d_cyc", c), {31'h0, wbm_cyc}, 32'h1);
        end
        tick(1);
        chk_rsp("to_rsp", 32'hFFFF_FFFF, 1'b1);
        wbm_ack    = 1'b1;                  // stray late ack
        wbm_dat_in = 32'h1111_1111;
        tick(2);
        chk_rsp("to_stray", 32'hFFFF_FFFF, 1'b1);
        wbm_ack   = 1'b0;
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
        chk_idle("to_done");
        wbm_ack = 1'b1;                     // stray ack while idle
        tick(1);
        wbm_ack = 1'b0;
        chk_idle("idle_stray");
        chk("idle_stray_rdy", {31'h0, cmd_ready}, 32'h1);

        // ---------------- Ack on the final timeout cycle ----------------
        set_cmd(1'b0, 32'h3000_000C, 32'h0, 4'hF);
        tick(1);
        cmd_valid = 1'b0;
        chk_bus("edge_c1", 1'b0, 32'h3000_000C, 32'h0, 4'hF);
        tick(7);
        chk("edge_c8_cyc", {31'h0, wbm_cyc}, 32'h1);
        wbm_ack    = 1'b1;
        wbm_dat_in = 32'hA5A5_A5A5;
        tick(1);
        wbm_ack = 1'b0;
        chk_rsp("edge_rsp", 32'hA5A5_A5A5, 1'b0);
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;

        // ---------------- Reset in cycle 3 of a wait ----------------
        set_cmd(1'b1, 32'h3000_0010, 32'h0BAD_F00D, 4'h1);
        tick(1);
        cmd_valid = 1'b0;
        chk_bus("mr_c1", 1'b1, 32'h3000_0010, 32'h0BAD_F00D, 4'h1);
        tick(2);
        chk("mr_c3_cyc", {31'h0, wbm_cyc}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("mr_async");
        chk("mr_async_rdy", {31'h0, cmd_ready}, 32'h0);
        chk("mr_async_adr", wbm_adr, 32'h0);
        tick(1);
        rst_n = 1'b1;
        #1;
        chk("mr_rel_rdy", {31'h0, cmd_ready}, 32'h0);
        tick(1);
        chk("mr_edge_rdy", {31'h0, cmd_ready}, 32'h1);
        chk_idle("mr_norsp");
        tick(2);
        chk("mr_later_rspv", {31'h0, rsp_valid}, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
